// File: rtl/axi_mem_responder.sv
// axi_mem_responder: single-transaction AXI4-style burst slave backed by on-chip RAM.
// 16-bit word addressing, INCR/FIXED bursts, SLVERR on illegal size/burst.
// Optional feature macro: AXI_RESP_WLAST_CHECK_EN adds a wlast port whose framing is
// cross-checked against the awlen beat count (mismatch -> SLVERR).
module axi_mem_responder #(
   parameter int unsigned ADDR_W     = 22,
   parameter int unsigned DEPTH_LOG2 = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [7:0]        awlen,
   input  logic [2:0]        awsize,
   input  logic [1:0]        awburst,
   input  logic              awvalid,
   output logic              awready,
   input  logic [15:0]       wdata,
   input  logic [1:0]        wstrb,
   input  logic              wvalid,
   output logic              wready,
`ifdef AXI_RESP_WLAST_CHECK_EN
   input  logic              wlast,
`endif
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [7:0]        arlen,
   input  logic [2:0]        arsize,
   input  logic [1:0]        arburst,
   input  logic              arvalid,
   output logic              arready,
   output logic [15:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;

   typedef enum logic [2:0] {StIdle, StWdata, StWresp, StRaddr, StRdata} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          len_q, len_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                incr_q, incr_d;
   logic                err_q, err_d;
   logic                ram_vld_q, ram_vld_d;
   logic                ram_last_q, ram_last_d;
   logic                fetch_done_q, fetch_done_d;
   logic                rvalid_q, rvalid_d;
   logic                rlast_q, rlast_d;
   logic [1:0]          rresp_q, rresp_d;
   logic [15:0]         rdata_q, rdata_d;
   logic [15:0]         ram_q;
   logic [15:0]         mem [Depth];
   logic [1:0]          mem_we;
   logic                fetch;
   logic                out_ld;
   logic [DEPTH_LOG2-1:0] ram_idx;

   function automatic logic cmd_ok(input logic [2:0] size, input logic [1:0] burst);
      return (size == 3'b001) && ((burst == 2'b00) || (burst == 2'b01));
   endfunction

   assign ram_idx = addr_q[DEPTH_LOG2-1:0];

   // Next-state: command latch, write beats, and the read fetch/output pipeline.
   // Read path: ram_q is the fetch stage (doubles as the skid entry), rdata_q the output stage.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      incr_d       = incr_q;
      err_d        = err_q;
      ram_vld_d    = ram_vld_q;
      ram_last_d   = ram_last_q;
      fetch_done_d = fetch_done_q;
      rvalid_d     = rvalid_q;
      rlast_d      = rlast_q;
      rresp_d      = rresp_q;
      rdata_d      = rdata_q;
      mem_we       = 2'b00;
      fetch        = 1'b0;
      out_ld       = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Write wins a simultaneous AW/AR; AR is simply not taken this cycle.
            if (awvalid) begin
               addr_d  = awaddr;
               len_d   = awlen;
               incr_d  = (awburst == 2'b01);
               err_d   = !cmd_ok(awsize, awburst);
               cnt_d   = 8'd0;
               state_d = StWdata;
            end else if (arvalid) begin
               addr_d       = araddr;
               len_d        = arlen;
               incr_d       = (arburst == 2'b01);
               err_d        = !cmd_ok(arsize, arburst);
               cnt_d        = 8'd0;
               ram_vld_d    = 1'b0;
               fetch_done_d = 1'b0;
               state_d      = StRaddr;
            end
         end
         StWdata: begin
            if (wvalid) begin
               if (!err_q) mem_we = wstrb;
`ifdef AXI_RESP_WLAST_CHECK_EN
               if (wlast != (cnt_q == len_q)) err_d = 1'b1;
`endif
               if (incr_q) addr_d = addr_q + ADDR_W'(1);
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == len_q) state_d = StWresp;
            end
         end
         StWresp: begin
            if (bready) state_d = StIdle;
         end
         StRaddr, StRdata: begin
            out_ld = ram_vld_q && (!rvalid_q || rready);
            fetch  = !fetch_done_q && (!ram_vld_q || out_ld);
            if (fetch) begin
               ram_vld_d  = 1'b1;
               ram_last_d = (cnt_q == len_q);
               if (cnt_q == len_q) fetch_done_d = 1'b1;
               cnt_d = cnt_q + 8'd1;
               if (incr_q) addr_d = addr_q + ADDR_W'(1);
            end else if (out_ld) begin
               ram_vld_d = 1'b0;
            end
            if (out_ld) begin
               rvalid_d = 1'b1;
               rdata_d  = err_q ? 16'h0000 : ram_q;
               rresp_d  = err_q ? 2'b10 : 2'b00;
               rlast_d  = ram_last_q;
            end else if (rvalid_q && rready) begin
               rvalid_d = 1'b0;
            end
            if (rvalid_q && rready && rlast_q) state_d = StIdle;
            if (state_q == StRaddr) state_d = StRdata;
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         len_q        <= 8'd0;
         cnt_q        <= 8'd0;
         incr_q       <= 1'b0;
         err_q        <= 1'b0;
         ram_vld_q    <= 1'b0;
         ram_last_q   <= 1'b0;
         fetch_done_q <= 1'b0;
         rvalid_q     <= 1'b0;
         rlast_q      <= 1'b0;
         rresp_q      <= 2'b00;
         rdata_q      <= 16'h0000;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         incr_q       <= incr_d;
         err_q        <= err_d;
         ram_vld_q    <= ram_vld_d;
         ram_last_q   <= ram_last_d;
         fetch_done_q <= fetch_done_d;
         rvalid_q     <= rvalid_d;
         rlast_q      <= rlast_d;
         rresp_q      <= rresp_d;
         rdata_q      <= rdata_d;
      end
   end

   // RAM with byte-enabled write and registered read; never reset so contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we[0]) mem[ram_idx][7:0]  <= wdata[7:0];
      if (mem_we[1]) mem[ram_idx][15:8] <= wdata[15:8];
      if (fetch)     ram_q <= mem[ram_idx];
   end

   // Handshake outputs; ready is masked while reset is held so reset values are all zero.
   assign awready = (state_q == StIdle) && !reset;
   assign arready = (state_q == StIdle) && !reset;
   assign wready  = (state_q == StWdata);
   assign bvalid  = (state_q == StWresp);
   assign bresp   = (bvalid && err_q) ? 2'b10 : 2'b00;
   assign rvalid  = rvalid_q;
   assign rlast   = rlast_q;
   assign rresp   = rresp_q;
   assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: stimulus pushes expected B/R responses into queues,
// a negedge monitor pops and compares whenever a B or R handshake is presented.
module tb_axi_mem_responder;

   localparam int unsigned AW = 22;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] awaddr = '0;
   logic [7:0]    awlen = 8'd0;
   logic [2:0]    awsize = 3'b001;
   logic [1:0]    awburst = 2'b01;
   logic          awvalid = 1'b0;
   logic          awready;
   logic [15:0]   wdata = 16'h0;
   logic [1:0]    wstrb = 2'b11;
   logic          wvalid = 1'b0;
   logic          wready;
   logic          wlast_tb = 1'b0;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready = 1'b1;
   logic [AW-1:0] araddr = '0;
   logic [7:0]    arlen = 8'd0;
   logic [2:0]    arsize = 3'b001;
   logic [1:0]    arburst = 2'b01;
   logic          arvalid = 1'b0;
   logic          arready;
   logic [15:0]   rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic          rvalid;
   logic          rready = 1'b1;

   typedef struct {
      logic [15:0] d;
      logic [1:0]  r;
      logic        l;
   } rexp_t;

   rexp_t       rq[$];
   logic [1:0]  bq[$];
   logic [15:0] wq[$];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   axi_mem_responder #(.ADDR_W(22), .DEPTH_LOG2(12)) dut (
      .clk     (clk),
      .reset   (reset),
      .awaddr  (awaddr),
      .awlen   (awlen),
      .awsize  (awsize),
      .awburst (awburst),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
`ifdef AXI_RESP_WLAST_CHECK_EN
      .wlast   (wlast_tb),
`endif
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready),
      .araddr  (araddr),
      .arlen   (arlen),
      .arsize  (arsize),
      .arburst (arburst),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rlast   (rlast),
      .rvalid  (rvalid),
      .rready  (rready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout/unexpected want handshake at %0t", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_r(input logic [15:0] d, input logic [1:0] r, input logic l);
      rexp_t e;
      e.d = d;
      e.r = r;
      e.l = l;
      rq.push_back(e);
   endtask

   task automatic aw_cmd(input logic [AW-1:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [2:0] s);
      int n = 0;
      awaddr = a; awlen = l; awburst = b; awsize = s; awvalid = 1'b1;
      while (!awready && n < 100) begin tick(); n++; end
      if (!awready) fail_now("aw_timeout");
      tick();
      awvalid = 1'b0;
   endtask

   task automatic ar_cmd(input logic [AW-1:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [2:0] s);
      int n = 0;
      araddr = a; arlen = l; arburst = b; arsize = s; arvalid = 1'b1;
      while (!arready && n < 100) begin tick(); n++; end
      if (!arready) fail_now("ar_timeout");
      tick();
      arvalid = 1'b0;
   endtask

   task automatic send_w(input logic [1:0] strb);
      for (int i = 0; i < wq.size(); i++) begin
         int n = 0;
         wdata = wq[i]; wstrb = strb; wlast_tb = (i == wq.size() - 1); wvalid = 1'b1;
         while (!wready && n < 100) begin tick(); n++; end
         if (!wready) fail_now("w_timeout");
         tick();
      end
      wvalid = 1'b0;
      wlast_tb = 1'b0;
      wq.delete();
   endtask

   task automatic wait_b();
      int n = 0;
      while (!bvalid && n < 100) begin tick(); n++; end
      if (!bvalid) begin fail_now("b_timeout"); bq.delete(); end
      else tick();
   endtask

   task automatic wait_r();
      int n = 0;
      while (rq.size() != 0 && n < 2000) begin tick(); n++; end
      if (rq.size() != 0) begin fail_now("r_timeout"); rq.delete(); end
   endtask

   task automatic write_txn(input logic [AW-1:0] a, input logic [7:0] l, input logic [1:0] b,
                            input logic [2:0] s, input logic [1:0] strb, input logic [1:0] eb);
      bq.push_back(eb);
      aw_cmd(a, l, b, s);
      send_w(strb);
      wait_b();
   endtask

   task automatic read_txn(input logic [AW-1:0] a, input logic [7:0] l, input logic [1:0] b,
                           input logic [2:0] s);
      ar_cmd(a, l, b, s);
      wait_r();
   endtask

   // Monitor: compares every B/R handshake against the queues and checks R stability on stall.
   logic        stall_v = 1'b0;
   logic [18:0] hold_v = '0;
   initial begin
      rexp_t e;
      logic [1:0] eb;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_v = 1'b0;
         end else begin
            if (stall_v) chk("r_hold", {13'd0, rdata, rresp, rlast}, {13'd0, hold_v});
            if (rvalid && rready) begin
               if (rq.size() == 0) fail_now("r_unexpected");
               else begin
                  e = rq.pop_front();
                  chk("rdata", {16'd0, rdata}, {16'd0, e.d});
                  chk("rresp", {30'd0, rresp}, {30'd0, e.r});
                  chk("rlast", {31'd0, rlast}, {31'd0, e.l});
               end
            end
            if (bvalid && bready) begin
               if (bq.size() == 0) fail_now("b_unexpected");
               else begin
                  eb = bq.pop_front();
                  chk("bresp", {30'd0, bresp}, {30'd0, eb});
               end
            end
            stall_v = rvalid && !rready;
            hold_v  = {rdata, rresp, rlast};
         end
      end
   end

   initial begin
      logic [3:0] pat;
      int k;
      pat = 4'b1001;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", {31'd0, awready}, 32'd0);
      chk("rst_arready", {31'd0, arready}, 32'd0);
      chk("rst_wready",  {31'd0, wready},  32'd0);
      chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
      chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
      chk("rst_rlast",   {31'd0, rlast},   32'd0);
      chk("rst_bresp",   {30'd0, bresp},   32'd0);
      chk("rst_rresp",   {30'd0, rresp},   32'd0);
      chk("rst_rdata",   {16'd0, rdata},   32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_awready", {31'd0, awready}, 32'd1);
      chk("post_rst_arready", {31'd0, arready}, 32'd1);

      // Basic INCR write/read with timing checks
      bq.push_back(2'b00);
      aw_cmd(22'h000010, 8'd3, 2'b01, 3'b001);
      chk("wready_after_aw", {31'd0, wready}, 32'd1);
      chk("awready_dropped", {31'd0, awready}, 32'd0);
      wq.push_back(16'h1111); wq.push_back(16'h2222);
      wq.push_back(16'h3333); wq.push_back(16'h4444);
      send_w(2'b11);
      chk("bvalid_after_last_w", {31'd0, bvalid}, 32'd1);
      wait_b();
      push_r(16'h1111, 2'b00, 1'b0); push_r(16'h2222, 2'b00, 1'b0);
      push_r(16'h3333, 2'b00, 1'b0); push_r(16'h4444, 2'b00, 1'b1);
      ar_cmd(22'h000010, 8'd3, 2'b01, 3'b001);
      chk("rvalid_lat0", {31'd0, rvalid}, 32'd0);
      tick();
      chk("rvalid_lat1", {31'd0, rvalid}, 32'd0);
      tick();
      chk("rvalid_lat2", {31'd0, rvalid}, 32'd1);
      wait_r();

      // Byte strobe: only low byte written
      wq.push_back(16'hFF99);
      write_txn(22'h000010, 8'd0, 2'b01, 3'b001, 2'b01, 2'b00);
      push_r(16'h1199, 2'b00, 1'b0); push_r(16'h1199, 2'b00, 1'b0);
      push_r(16'h1199, 2'b00, 1'b1);
      read_txn(22'h000010, 8'd2, 2'b00, 3'b001);

      // FIXED write: last beat wins
      wq.push_back(16'h0001); wq.push_back(16'h0002); wq.push_back(16'h0003);
      write_txn(22'h000040, 8'd2, 2'b00, 3'b001, 2'b11, 2'b00);
      push_r(16'h0003, 2'b00, 1'b1);
      read_txn(22'h000040, 8'd0, 2'b01, 3'b001);

      // AW and AR together: write first, read held off until B completes
      push_r(16'hBEEF, 2'b00, 1'b1);
      bq.push_back(2'b00);
      awaddr = 22'h000020; awlen = 8'd0; awburst = 2'b01; awsize = 3'b001; awvalid = 1'b1;
      araddr = 22'h000020; arlen = 8'd0; arburst = 2'b01; arsize = 3'b001; arvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("coll_awready_low", {31'd0, awready}, 32'd0);
      chk("coll_arready_low", {31'd0, arready}, 32'd0);
      wq.push_back(16'hBEEF);
      send_w(2'b11);
      chk("coll_arready_in_b", {31'd0, arready}, 32'd0);
      wait_b();
      chk("coll_arready_back", {31'd0, arready}, 32'd1);
      tick();
      arvalid = 1'b0;
      wait_r();

      // Illegal burst: SLVERR, RAM untouched
      wq.push_back(16'hAAAA); wq.push_back(16'h5555);
      write_txn(22'h000030, 8'd1, 2'b01, 3'b001, 2'b11, 2'b00);
      wq.push_back(16'h1234); wq.push_back(16'h5678);
      write_txn(22'h000030, 8'd1, 2'b10, 3'b001, 2'b11, 2'b10);
      push_r(16'hAAAA, 2'b00, 1'b0); push_r(16'h5555, 2'b00, 1'b1);
      read_txn(22'h000030, 8'd1, 2'b01, 3'b001);
      push_r(16'h0000, 2'b10, 1'b1);
      read_txn(22'h000030, 8'd0, 2'b11, 3'b001);
      push_r(16'h0000, 2'b10, 1'b0); push_r(16'h0000, 2'b10, 1'b1);
      read_txn(22'h000030, 8'd1, 2'b01, 3'b010);

      // rready pattern 1,0,0,1 on an 8-beat read
      for (int i = 0; i < 8; i++) wq.push_back(16'hA000 + 16'(i));
      write_txn(22'h000100, 8'd7, 2'b01, 3'b001, 2'b11, 2'b00);
      for (int i = 0; i < 8; i++) push_r(16'hA000 + 16'(i), 2'b00, i == 7);
      ar_cmd(22'h000100, 8'd7, 2'b01, 3'b001);
      k = 0;
      while (rq.size() != 0 && k < 200) begin
         rready = pat[k % 4];
         tick();
         k++;
      end
      rready = 1'b1;
      if (rq.size() != 0) begin fail_now("stall_r_timeout"); rq.delete(); end

      // 256-beat write wrapping the top of the RAM
      for (int i = 0; i < 256; i++) wq.push_back(16'hC000 + 16'(i));
      write_txn(22'd4094, 8'd255, 2'b01, 3'b001, 2'b11, 2'b00);
      for (int i = 0; i < 256; i++) push_r(16'hC000 + 16'(i), 2'b00, i == 255);
      read_txn(22'd4094, 8'd255, 2'b01, 3'b001);
      for (int i = 0; i < 4; i++) push_r(16'hC002 + 16'(i), 2'b00, i == 3);
      read_txn(22'd0, 8'd3, 2'b01, 3'b001);
      push_r(16'hC002, 2'b00, 1'b1);
      read_txn(22'h001000, 8'd0, 2'b01, 3'b001);
      push_r(16'hC001, 2'b00, 1'b0); push_r(16'hC002, 2'b00, 1'b1);
      read_txn(22'h3FFFFF, 8'd1, 2'b01, 3'b001);

      // Reset in the middle of WDATA
      aw_cmd(22'h000200, 8'd3, 2'b01, 3'b001);
      wdata = 16'hD001; wstrb = 2'b11; wvalid = 1'b1;
      tick();
      wdata = 16'hD002;
      tick();
      reset = 1'b1;
      wvalid = 1'b0;
      #1;
      chk("mid_rst_awready", {31'd0, awready}, 32'd0);
      chk("mid_rst_wready",  {31'd0, wready},  32'd0);
      chk("mid_rst_bvalid",  {31'd0, bvalid},  32'd0);
      chk("mid_rst_rvalid",  {31'd0, rvalid},  32'd0);
      chk("mid_rst_rdata",   {16'd0, rdata},   32'd0);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("rel_awready", {31'd0, awready}, 32'd1);
      chk("rel_wready",  {31'd0, wready},  32'd0);
      push_r(16'hA000, 2'b00, 1'b1);
      read_txn(22'h000100, 8'd0, 2'b01, 3'b001);
      push_r(16'hD001, 2'b00, 1'b0); push_r(16'hD002, 2'b00, 1'b1);
      read_txn(22'h000200, 8'd1, 2'b01, 3'b001);
      push_r(16'hC002, 2'b00, 1'b1);
      read_txn(22'd0, 8'd0, 2'b01, 3'b001);

      repeat (3) tick();
      if (bq.size() != 0) fail_now("b_leftover");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4-style burst responder (slave) backed by on-chip RAM, answering the same user write/read channels our SDRAM traffic generators drive. Stands in for the SDRAM controller during bring-up and simulation, so the initiator-side pattern testers can run against a known-good memory. It handles one transaction at a time and uses 16-bit word addressing with INCR/FIXED bursts.

## Interface
- `ADDR_W`, 22: address width in 16-bit words
- `DEPTH_LOG2`, 12: RAM holds 2^DEPTH_LOG2 words; address bits above are ignored (modulo wrap)
- `clk` in 1: clock, all logic on rising edge
- `reset` in 1: asynchronous, active-high reset
- `awaddr` in ADDR_W: write start word address
- `awlen` in 8: beats − 1
- `awsize` in 3: must be 3'b001
- `awburst` in 2: 00 FIXED, 01 INCR, others illegal
- `awvalid` in 1 / `awready` out 1: write address handshake
- `wdata` in 16, `wstrb` in 2: write data, byte enables (bit0 = [7:0])
- `wvalid` in 1 / `wready` out 1: write data handshake
- `wlast` in 1: present only with `AXI_RESP_WLAST_CHECK_EN`
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response
- `araddr` in ADDR_W, `arlen` in 8, `arsize` in 3, `arburst` in 2: read command, same encodings as write
- `arvalid` in 1 / `arready` out 1: read address handshake
- `rdata` out 16, `rresp` out 2, `rlast` out 1: read data beat
- `rvalid` out 1 / `rready` in 1: read data handshake

## Operation
- States: IDLE, WDATA, WRESP, RADDR, RDATA.
- IDLE: `awready` = `arready` = 1, which is the only state where either is high. A handshake happens on valid&ready. If `awvalid` and `arvalid` are both high in the same cycle, the write wins and `arready` stays 1 only until that edge.
- Write: latch addr/len/burst; check `awsize`==001 and `awburst`∈{00,01}, otherwise the error flag is set. → WDATA.
- WDATA: `wready`=1. Each wvalid&wready beat writes RAM[addr] per `wstrb` (writes are suppressed if the error flag is set). Then addr += 1 for INCR, or stays for FIXED. The beat counter counts awlen+1 beats. On the final beat → WRESP.
- WRESP: `bvalid`=1, `bresp` = 2'b10 (SLVERR) if the error flag is set, else 2'b00. Stays in WRESP until `bready`, then → IDLE.
- Read: latch command, run the same legality check → RADDR (one RAM read issued) → RDATA.
- RDATA: beats carry RAM contents (or 16'h0000 with `rresp`=10 on error). `rlast`=1 on beat arlen+1. A beat completes on rvalid&rready. After the last beat → IDLE.
- Address arithmetic is ADDR_W bits and wraps mod 2^ADDR_W. The RAM index uses the low DEPTH_LOG2 bits. A 256-beat burst across the top wraps to word 0.
- Reset mid-operation: the transaction is abandoned, all outputs go to reset values, and RAM contents are preserved (RAM is not reset).

## Timing
- Reset values: `awready`, `arready`, `wready`, `bvalid`, `rvalid`, `rlast` = 0; `bresp`, `rresp` = 2'b00; `rdata` = 0.
- The first cycle after reset deassertion is IDLE with `awready` = `arready` = 1.
- Ready signals drop in the cycle after the AW/AR handshake edge. Initiators detect acceptance by ready going low.
- `wready` rises the cycle after the AW handshake. `bvalid` rises the cycle after the last W beat.
- The first `rvalid` comes 2 cycles after the AR handshake. Beats then follow back-to-back while `rready`=1 (registered RAM output plus a one-entry skid buffer).
- When `rready`=0, `rdata`/`rlast`/`rresp` hold stable.
- Return to IDLE takes 1 cycle after the final B/R handshake, so the back-to-back command turnaround is 1 cycle.

## Configuration
- `AXI_RESP_WLAST_CHECK_EN` defined: the `wlast` port exists. `wlast`=1 on a beat other than the counted last, or `wlast`=0 on the counted last, sets the error flag (→ SLVERR). The burst still terminates on the beat count.
- Not defined: there is no `wlast` port, and termination is purely by the awlen count.

## Test plan
- Write awaddr=0x000010, awlen=3, INCR, data 0x1111..0x4444, then read the same → rdata 0x1111,0x2222,0x3333,0x4444, `rlast` on the 4th, `bresp`=`rresp`=00.
- AW and AR asserted in the same cycle → write accepted first, `arready` low until B completes, then read is accepted and returns the newly written data.
- awburst=2'b10 with awlen=1, preceded by a known value at the target → bresp=10, RAM unchanged on readback.
- `rready` toggled 1,0,0,1 during an arlen=7 read → every beat delivered once, in order, with data held stable while stalled.
- 256-beat INCR write starting at word 2^DEPTH_LOG2−2 → the last 254 beats land at words 0..253, verified by readback.
- `reset` pulsed in the middle of WDATA → outputs return to reset values, the next cycle after release shows `awready`=1, and previously written words remain intact.
